// File: rtl/rx_frame_sync.sv
// Frame synchroniser for a strobed serial bit stream: hunts for a sync marker,
// then alternates codeword capture and marker checking with a miss flywheel.
module rx_frame_sync #(
  parameter logic [7:0] SYNC_WORD = 8'h7E,
  parameter int         CW_LEN    = 16,
  parameter int         MAX_MISS  = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_stb,
  output logic [CW_LEN-1:0] codeword,
  output logic              cw_valid,
  output logic              sync_lock,
  output logic [7:0]        frame_cnt,
  output logic [2:0]        miss_cnt,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2((CW_LEN > 8) ? CW_LEN : 8);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_q;
  logic [6:0]        window_q;
  logic [6:0]        marker_q;
  logic [CW_LEN-2:0] cap_q;
  logic [CW_LEN-1:0] codeword_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cw_valid_q;
  logic              lock_q;
  logic [7:0]        frame_q;
  logic [2:0]        miss_q;

  // Shift registers keep only the older bits; the _d views include the bit
  // being strobed now, so a match is seen on the edge that completes it.
  logic [7:0]        window_d;
  logic [7:0]        marker_d;
  logic [CW_LEN-1:0] cap_d;
  logic [3:0]        miss_inc;
  logic              flywheel;

  assign window_d = {window_q, bit_in};
  assign marker_d = {marker_q, bit_in};
  assign cap_d    = {cap_q, bit_in};
  assign miss_inc = {1'b0, miss_q} + 4'd1;
  assign flywheel = (miss_inc < 4'(MAX_MISS));

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      window_q   <= '0;
      marker_q   <= '0;
      cap_q      <= '0;
      codeword_q <= '0;
      cnt_q      <= '0;
      cw_valid_q <= 1'b0;
      lock_q     <= 1'b0;
      frame_q    <= '0;
      miss_q     <= '0;
    end else begin
      cw_valid_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bit_stb) begin
            window_q <= window_d[6:0];
            if (window_d == SYNC_WORD) begin
              state_q <= DATA;
              cnt_q   <= '0;
              lock_q  <= 1'b1;
              miss_q  <= '0;
            end
          end
        end
        DATA: begin
          if (bit_stb) begin
            cap_q <= cap_d[CW_LEN-2:0];
            if (cnt_q == CNT_W'(CW_LEN - 1)) begin
              codeword_q <= cap_d;
              cw_valid_q <= 1'b1;
              frame_q    <= frame_q + 8'd1;
              cnt_q      <= '0;
              marker_q   <= '0;
              state_q    <= CHECK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (bit_stb) begin
            marker_q <= marker_d[6:0];
            if (cnt_q == CNT_W'(7)) begin
              cnt_q <= '0;
              if (marker_d == SYNC_WORD) begin
                miss_q  <= '0;
                state_q <= DATA;
              end else if (flywheel) begin
                miss_q  <= miss_q + 3'd1;
                state_q <= DATA;
              end else begin
                // Too many bad markers: fall back to a clean hunt.
                miss_q   <= '0;
                lock_q   <= 1'b0;
                window_q <= '0;
                state_q  <= HUNT;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign codeword    = codeword_q;
  assign cw_valid    = cw_valid_q;
  assign sync_lock   = lock_q;
  assign frame_cnt   = frame_q;
  assign miss_cnt    = miss_q;
  assign dbg_state_o = state_q;

endmodule
